// File: rtl/uart_rx_frame.sv
// UART receive framer: 2-flop sync, 3-tap mid-bit majority, parity/stop checks.
// Good bytes land in a valid/ready output register; errors are 1-cycle pulses.
module uart_rx_frame #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_vld,
  input  logic                 rx_rdy,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 ovr_err,
  output logic                 busy
);

  localparam int CPB  = CLK_HZ / BAUD;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int IW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] T_LO   = CW'(HALF - 1);
  localparam logic [CW-1:0] T_MID  = CW'(HALF);
  localparam logic [CW-1:0] T_HI   = CW'(HALF + 1);
  localparam logic [CW-1:0] T_END  = CW'(CPB - 1);
  localparam logic [CW-1:0] T_QUAL = CW'(3);
  localparam logic [IW-1:0] I_LAST = IW'(DATA_BITS - 1);
  localparam logic          P_ODD  = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_WAIT,
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 t0_q, t0_d;
  logic                 t1_q, t1_d;
  logic                 par_bad_q, par_bad_d;
  logic                 dlv_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_vld_q;
  logic                 par_err_q, frm_err_q, ovr_err_q;
  logic                 frm_set, par_set, dlv_set;

  logic rxs, maj, at_hi, at_end;

  assign rxs    = sync_q[1];
  assign maj    = (t0_q & t1_q) | (t0_q & rxs) | (t1_q & rxs);
  assign at_hi  = (cnt_q == T_HI);
  assign at_end = (cnt_q == T_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:  if (rxs && cnt_q == T_QUAL) state_d = S_IDLE;
      S_IDLE:  if (!rxs) state_d = S_START;
      S_START: begin
        if (at_hi && maj)  state_d = S_IDLE;
        else if (at_end)   state_d = S_DATA;
      end
      S_DATA: begin
        if (at_end && idx_q == I_LAST)
          state_d = (PARITY_EN != 0) ? S_PAR : S_STOP;
      end
      S_PAR:   if (at_end) state_d = S_STOP;
      S_STOP:  if (at_hi) state_d = maj ? S_IDLE : S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  always_comb begin
    cnt_d     = at_end ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    t0_d      = (cnt_q == T_LO)  ? rxs : t0_q;
    t1_d      = (cnt_q == T_MID) ? rxs : t1_q;
    par_bad_d = par_bad_q;
    frm_set   = 1'b0;
    par_set   = 1'b0;
    dlv_set   = 1'b0;
    busy      = (state_q != S_IDLE);
    unique case (state_q)
      // the line must read high for several real samples before idling,
      // so reset-valued sync flops cannot fake an idle line
      S_WAIT: if (!rxs) cnt_d = '0;
      S_IDLE: begin
        cnt_d     = '0;
        idx_d     = '0;
        par_bad_d = 1'b0;
      end
      S_START: ;
      S_DATA: begin
        if (at_hi)  shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (at_end) idx_d   = idx_q + 1'b1;
      end
      S_PAR: if (at_hi) par_bad_d = ((maj ^ (^shift_q)) != P_ODD);
      S_STOP: begin
        if (at_hi) begin
          if (!maj)           frm_set = 1'b1;
          else if (par_bad_q) par_set = 1'b1;
          else                dlv_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      t0_q      <= 1'b1;
      t1_q      <= 1'b1;
      par_bad_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      t0_q      <= t0_d;
      t1_q      <= t1_d;
      par_bad_q <= par_bad_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dlv_q     <= 1'b0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
    end else begin
      dlv_q     <= dlv_set;
      par_err_q <= par_set;
      frm_err_q <= frm_set;
      ovr_err_q <= dlv_q & rx_vld_q & ~rx_rdy;
      // a fresh byte wins over a same-cycle consume
      if (dlv_q && (!rx_vld_q || rx_rdy)) begin
        rx_data_q <= shift_q;
        rx_vld_q  <= 1'b1;
      end else if (rx_vld_q && rx_rdy) begin
        rx_vld_q  <= 1'b0;
      end
    end
  end

  assign rx_data = rx_data_q;
  assign rx_vld  = rx_vld_q;
  assign par_err = par_err_q;
  assign frm_err = frm_err_q;
  assign ovr_err = ovr_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame at defaults (434 clks/bit, 8E1).
// Directed scenarios plus random frames checked against a frame-outcome model.
module tb_uart_rx_frame;

  localparam int CPB = 50_000_000 / 115200;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic       rx_rdy = 1'b1;
  logic [7:0] rx_data;
  logic       rx_vld, par_err, frm_err, ovr_err, busy;

  always #10 clk = ~clk;

  uart_rx_frame dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_vld  (rx_vld),
    .rx_rdy  (rx_rdy),
    .par_err (par_err),
    .frm_err (frm_err),
    .ovr_err (ovr_err),
    .busy    (busy)
  );

  int errors = 0;
  int checks = 0;

  int         n_par = 0, n_frm = 0, n_ovr = 0, n_vld = 0, n_acc = 0;
  logic [7:0] last_acc = '0;
  int         b_par, b_frm, b_ovr, b_vld, b_acc;

  always @(negedge clk) begin
    if (par_err) n_par <= n_par + 1;
    if (frm_err) n_frm <= n_frm + 1;
    if (ovr_err) n_ovr <= n_ovr + 1;
    if (rx_vld)  n_vld <= n_vld + 1;
    if (rx_vld && rx_rdy) begin
      n_acc    <= n_acc + 1;
      last_acc <= rx_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    hold(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p,
                            input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    rx = 1'b1;
  endtask

  // even parity: bit that makes the count of ones even
  function automatic logic good_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return logic'(ones % 2);
  endfunction

  // 0 = byte delivered, 1 = parity error, 2 = framing error
  function automatic int outcome(input logic [7:0] d, input logic p,
                                 input logic s);
    if (!s) return 2;
    if (p != good_par(d)) return 1;
    return 0;
  endfunction

  task automatic snap();
    b_par = n_par;
    b_frm = n_frm;
    b_ovr = n_ovr;
    b_vld = n_vld;
    b_acc = n_acc;
  endtask

  task automatic expect_ev(input string tag, input int par, input int frm,
                           input int ovr, input int acc);
    chk({tag, ".par"}, n_par - b_par, par);
    chk({tag, ".frm"}, n_frm - b_frm, frm);
    chk({tag, ".ovr"}, n_ovr - b_ovr, ovr);
    chk({tag, ".acc"}, n_acc - b_acc, acc);
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s;
    int         sel, k;

    hold(3);
    chk("rst.busy", busy, 1);
    chk("rst.vld", rx_vld, 0);
    chk("rst.data", rx_data, 0);
    chk("rst.errs", {par_err, frm_err, ovr_err}, 0);
    rst_n = 1'b1;
    hold(10);
    chk("idle.busy", busy, 0);

    snap();
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    hold(20);
    expect_ev("a5", 0, 0, 0, 1);
    chk("a5.data", last_acc, 8'hA5);
    chk("a5.vldw", n_vld - b_vld, 1);

    snap();
    rx = 1'b0;
    hold(150);
    rx = 1'b1;
    chk("glitch.busy_in", busy, 1);
    hold(CPB);
    chk("glitch.busy_out", busy, 0);
    expect_ev("glitch", 0, 0, 0, 0);
    chk("glitch.vld", n_vld - b_vld, 0);

    snap();
    send_frame(8'h3C, 1'b1, 1'b1);
    hold(20);
    expect_ev("par3c", 1, 0, 0, 0);
    chk("par3c.vld", n_vld - b_vld, 0);

    snap();
    send_frame(8'h55, good_par(8'h55), 1'b0);
    hold(20);
    expect_ev("frm55", 0, 1, 0, 0);
    snap();
    send_frame(8'h12, good_par(8'h12), 1'b1);
    hold(20);
    expect_ev("after_frm", 0, 0, 0, 1);
    chk("after_frm.data", last_acc, 8'h12);

    rx_rdy = 1'b0;
    snap();
    send_frame(8'h01, good_par(8'h01), 1'b1);
    hold(20);
    chk("ovr.vld1", rx_vld, 1);
    chk("ovr.data1", rx_data, 8'h01);
    send_frame(8'h02, good_par(8'h02), 1'b1);
    hold(20);
    expect_ev("ovr", 0, 0, 1, 0);
    chk("ovr.held", rx_data, 8'h01);
    chk("ovr.vld2", rx_vld, 1);
    rx_rdy = 1'b1;
    hold(2);
    chk("ovr.clr", rx_vld, 0);
    chk("ovr.acc", last_acc, 8'h01);

    snap();
    send_bit(1'b0);
    for (int i = 0; i < 7; i++) send_bit(d_77(i));
    rx = 1'b0;
    hold(CPB / 2);
    rst_n = 1'b0;
    hold(5);
    chk("midrst.busy", busy, 1);
    rst_n = 1'b1;
    hold(CPB / 2 - 5);
    chk("midrst.wait", busy, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    hold(20);
    expect_ev("midrst", 0, 0, 0, 0);
    chk("midrst.vld", n_vld - b_vld, 0);
    chk("midrst.idle", busy, 0);
    snap();
    send_frame(8'h99, good_par(8'h99), 1'b1);
    hold(20);
    expect_ev("after_rst", 0, 0, 0, 1);
    chk("after_rst.data", last_acc, 8'h99);

    for (int n = 0; n < 6; n++) begin
      d   = 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 3);
      p   = good_par(d) ^ (sel == 0);
      s   = (sel != 1);
      k   = outcome(d, p, s);
      snap();
      send_frame(d, p, s);
      hold(20);
      expect_ev($sformatf("rnd%0d", n), int'(k == 1), int'(k == 2), 0,
                int'(k == 0));
      if (k == 0) chk($sformatf("rnd%0d.data", n), last_acc, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic d_77(input int i);
    logic [7:0] v;
    v = 8'h77;
    return v[i];
  endfunction

endmodule
